// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The master modport is the loader side; slave is the source/memory side.
interface imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;

  modport master (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length-prefixed, XOR-checked byte frame into
// little-endian 32-bit writes while holding the core in reset.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned BASE_ADDR   = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          core_hold,
  output logic          busy,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    StIdle, StLenLo, StLenHi, StData, StWrite, StCheck, StDone, StErr
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           n_q, n_d;
  logic [15:0]           word_idx_q, word_idx_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [7:0]            xor_q, xor_d;
  logic [31:0]           word_q, word_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  wr_en_q, wr_en_d;
  logic                  core_hold_q, core_hold_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  accept;
  logic [15:0]           len_full;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    xor_d      = xor_q;
    word_d     = word_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    accept     = byte_ready_q & bus.byte_valid;
    len_full   = {bus.byte_data, n_q[7:0]};

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d    = StLenLo;
          word_idx_d = '0;
          byte_idx_d = '0;
          xor_d      = '0;
        end
      end
      StLenLo: begin
        if (accept) begin
          n_d[7:0] = bus.byte_data;
          state_d  = StLenHi;
        end
      end
      StLenHi: begin
        if (accept) begin
          n_d[15:8] = bus.byte_data;
          if (32'(len_full) > DEPTH_WORDS) begin
            state_d = StErr;
          end else if (len_full == 16'd0) begin
            state_d = StCheck;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          word_d[8*byte_idx_q +: 8] = bus.byte_data;
          xor_d = xor_q ^ bus.byte_data;
          if (byte_idx_q == 2'd3) begin
            // Latch the complete word and its address so WRITE drives stable values.
            byte_idx_d = '0;
            wr_data_d  = word_d;
            wr_addr_d  = ADDR_WIDTH'(BASE_ADDR) + (ADDR_WIDTH'(word_idx_q) << 2);
            state_d    = StWrite;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      StWrite: begin
        word_idx_d = word_idx_q + 16'd1;
        state_d    = (word_idx_d == n_q) ? StCheck : StData;
      end
      StCheck: begin
        if (accept) begin
          state_d = (bus.byte_data == xor_q) ? StDone : StErr;
        end
      end
      default: state_d = StIdle;
    endcase

    // Status outputs are registered from the next state so they line up with it.
    byte_ready_d = state_d inside {StLenLo, StLenHi, StData, StCheck};
    wr_en_d      = (state_d == StWrite);
    busy_d       = state_d inside {StLenLo, StLenHi, StData, StWrite, StCheck};
    core_hold_d  = !(state_d inside {StIdle, StDone});
    done_d       = (state_d == StDone);
    error_d      = (state_d == StErr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      n_q          <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      xor_q        <= '0;
      word_q       <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      core_hold_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      xor_q        <= xor_d;
      word_q       <= word_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      core_hold_q  <= core_hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign core_hold      = core_hold_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: frames are scored against a frame-level model that
// derives the expected writes and pass/fail result directly from the byte stream.
module tb_imem_loader;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned BASE  = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic core_hold, busy, done, error;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(
    .ADDR_WIDTH (AW),
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .core_hold(core_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  frame[$];
  logic [31:0] exp_addr[$], exp_data[$];
  logic [31:0] obs_addr[$], obs_data[$];
  bit          exp_ok;
  int          exp_consumed;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Write-port monitor; byte_ready must be low whenever a write is issued.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      obs_addr.push_back(bus.wr_addr);
      obs_data.push_back(bus.wr_data);
      check_eq("ready_low_in_write", {63'd0, bus.byte_ready}, 64'd0);
    end
  end

  task automatic new_frame(input int n);
    frame.delete();
    frame.push_back(n[7:0]);
    frame.push_back(n[15:8]);
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) frame.push_back(w[8*b +: 8]);
  endtask

  function automatic logic [7:0] payload_xor();
    logic [7:0] x = 8'h00;
    for (int k = 2; k < frame.size(); k++) x ^= frame[k];
    return x;
  endfunction

  // Reference: what a correct loader must write and conclude for the current frame.
  task automatic model_frame();
    int n;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    n = int'(frame[0]) + 256 * int'(frame[1]);
    if (n > int'(DEPTH)) begin
      exp_consumed = 2;
      exp_ok       = 1'b0;
      return;
    end
    exp_consumed = 2 + 4 * n + 1;
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      exp_addr.push_back(BASE + 4 * k);
      exp_data.push_back({frame[2+4*k+3], frame[2+4*k+2], frame[2+4*k+1], frame[2+4*k]});
      for (int b = 0; b < 4; b++) x ^= frame[2+4*k+b];
    end
    exp_ok = (frame[2+4*n] == x);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input string name, input int valid_pct, input int mid_start_at);
    int  i = 0;
    int  cyc = 0;
    int  budget;
    bit  acc;
    model_frame();
    obs_addr.delete();
    obs_data.delete();
    pulse_start();
    check_eq({name, "_busy_after_start"}, {63'd0, busy}, 64'd1);
    check_eq({name, "_hold_after_start"}, {63'd0, core_hold}, 64'd1);
    budget = 20 * exp_consumed + 100;
    while (i < exp_consumed && cyc < budget) begin
      bus.byte_valid = ($urandom_range(99) < valid_pct);
      bus.byte_data  = frame[i];
      start          = (i == mid_start_at && i > 2);
      acc            = bus.byte_valid && bus.byte_ready;
      @(posedge clk);
      if (acc) i++;
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    bus.byte_valid = 1'b0;
    check_eq({name, "_bytes_consumed"}, 64'(i), 64'(exp_consumed));
    // One cycle after the final accepted byte the verdict must be visible.
    check_eq({name, "_done"}, {63'd0, done}, {63'd0, exp_ok});
    check_eq({name, "_error"}, {63'd0, error}, {63'd0, !exp_ok});
    check_eq({name, "_hold"}, {63'd0, core_hold}, {63'd0, !exp_ok});
    check_eq({name, "_busy_end"}, {63'd0, busy}, 64'd0);
    check_eq({name, "_ready_end"}, {63'd0, bus.byte_ready}, 64'd0);
    repeat (3) @(negedge clk);
    check_eq({name, "_write_count"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
    for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
      check_eq({name, "_addr"}, 64'(obs_addr[k]), 64'(exp_addr[k]));
      check_eq({name, "_data"}, 64'(obs_data[k]), 64'(exp_data[k]));
    end
  endtask

  task automatic frame1(input bit good);
    new_frame(2);
    add_word(32'h0010_0513);
    add_word(32'h0020_0593);
    frame.push_back(good ? payload_xor() : 8'h00);
  endtask

  initial begin
    int  i;
    int  cyc;
    bit  acc;
    bit  hit;
    int  n;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    #2;
    check_eq("reset_hold", {63'd0, core_hold}, 64'd0);
    check_eq("reset_busy", {63'd0, busy}, 64'd0);
    check_eq("reset_wr_en", {63'd0, bus.wr_en}, 64'd0);
    check_eq("reset_ready", {63'd0, bus.byte_ready}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("idle_done", {63'd0, done}, 64'd0);
    check_eq("idle_error", {63'd0, error}, 64'd0);

    frame1(1'b1);
    run_frame("t1_good", 100, -1);

    frame1(1'b0);
    run_frame("t2_badcks", 100, -1);
    repeat (5) @(negedge clk);
    check_eq("t2_hold_persists", {63'd0, core_hold}, 64'd1);
    check_eq("t2_error_persists", {63'd0, error}, 64'd1);

    new_frame(257);
    run_frame("t3_toolong", 100, -1);

    new_frame(0);
    frame.push_back(8'h00);
    run_frame("t4_empty_ok", 100, -1);
    new_frame(0);
    frame.push_back(8'hFF);
    run_frame("t4_empty_bad", 100, -1);

    frame1(1'b1);
    run_frame("t5_gaps_midstart", 50, 5);

    for (int t = 0; t < 5; t++) begin
      n = $urandom_range(6, 1);
      new_frame(n);
      for (int k = 0; k < n; k++) add_word($urandom);
      frame.push_back(($urandom_range(1) == 1) ? payload_xor() : payload_xor() ^ 8'h5A);
      run_frame("rand", 60, $urandom_range(4 * n, 3));
    end

    new_frame(DEPTH);
    for (int k = 0; k < int'(DEPTH); k++) add_word($urandom);
    frame.push_back(payload_xor());
    run_frame("full_depth", 100, -1);
    check_eq("full_depth_last_addr", 64'(obs_addr[obs_addr.size()-1]),
             64'(BASE + 4 * (DEPTH - 1)));

    // Reset in the middle of a load, just after the first word is written.
    frame1(1'b1);
    obs_addr.delete();
    obs_data.delete();
    pulse_start();
    i = 0;
    cyc = 0;
    hit = 1'b0;
    while (!hit && cyc < 50) begin
      bus.byte_valid = 1'b1;
      bus.byte_data  = frame[i];
      acc            = bus.byte_ready;
      @(posedge clk);
      if (acc) i++;
      @(negedge clk);
      cyc++;
      hit = bus.wr_en;
    end
    check_eq("t6_first_write_seen", {63'd0, hit}, 64'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("t6_async_hold", {63'd0, core_hold}, 64'd0);
    check_eq("t6_async_busy", {63'd0, busy}, 64'd0);
    check_eq("t6_async_ready", {63'd0, bus.byte_ready}, 64'd0);
    check_eq("t6_async_wr_en", {63'd0, bus.wr_en}, 64'd0);
    check_eq("t6_async_addr", 64'(bus.wr_addr), 64'd0);
    check_eq("t6_async_data", 64'(bus.wr_data), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    bus.byte_valid = 1'b0;
    check_eq("t6_no_more_writes", 64'(obs_addr.size()), 64'd1);
    check_eq("t6_idle_hold", {63'd0, core_hold}, 64'd0);
    check_eq("t6_idle_busy", {63'd0, busy}, 64'd0);
    run_frame("t6_reload", 100, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
